// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS noise-cancellation engine.
package lms_pkg;

  typedef enum logic [2:0] {IDLE, UPDATE, INSERT, FILTER, DONE} state_e;

  // Accumulator width that cannot overflow over a full NTAPS-term dot product.
  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lms_coef_bank.sv
// Coefficient storage with a single read-modify-write LMS update port and an
// independent registered readback port. Leaky update when LMS_LEAK_EN is defined.
module lms_coef_bank
  import lms_pkg::*;
#(
  parameter int NTAPS      = 64,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 18,
  parameter int MU_SHIFT   = 20,
  parameter int LEAK_SHIFT = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       upd_i,
  input  logic [$clog2(NTAPS)-1:0]   k_i,
  input  logic [$clog2(NTAPS)-1:0]   ridx_i,
  input  logic signed [DATA_W-1:0]   err_i,
  input  logic signed [DATA_W-1:0]   x_i,
  output logic signed [COEF_W-1:0]   w_o,
  output logic signed [COEF_W-1:0]   coef_o
);

  logic signed [COEF_W-1:0]   w_q [NTAPS];
  logic signed [2*DATA_W-1:0] prod, delta;
  logic signed [COEF_W-1:0]   w_d;
  longint                     sum;

  // Update datapath: delta = (err*x) >>> MU_SHIFT, added to w[k] and saturated.
  always_comb begin
    w_o   = w_q[k_i];
    prod  = err_i * x_i;
    delta = prod >>> MU_SHIFT;
`ifdef LMS_LEAK_EN
    sum   = longint'(w_o) - longint'(w_o >>> LEAK_SHIFT) + longint'(delta);
`else
    sum   = longint'(w_o) + longint'(delta);
`endif
    w_d   = COEF_W'(sat(sum, COEF_W));
  end

  // Coefficient write and readback; readback sees the pre-update value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NTAPS; i++) w_q[i] <= '0;
      coef_o <= '0;
    end else begin
      if (upd_i) w_q[k_i] <= w_d;
      coef_o <= w_q[ridx_i];
    end
  end

endmodule

// File: rtl/lms_anc_engine.sv
// Time-multiplexed adaptive noise-cancellation engine: circular sample buffer,
// LMS weight update and FIR filter sharing one datapath.
// Optional leaky LMS update: define LMS_LEAK_EN.
module lms_anc_engine
  import lms_pkg::*;
#(
  parameter int NTAPS      = 64,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 18,
  parameter int FRAC_BITS  = 15,
  parameter int MU_SHIFT   = 20,
  parameter int LEAK_SHIFT = 12
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       ready_in,
  input  logic signed [DATA_W-1:0]   x_in,
  input  logic signed [DATA_W-1:0]   err_in,
  input  logic                       adapt_en,
  input  logic [$clog2(NTAPS)-1:0]   coef_idx_in,
  output logic signed [COEF_W-1:0]   coef_out,
  output logic signed [DATA_W-1:0]   y_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW    = $clog2(NTAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int PW    = DATA_W + COEF_W;

  state_e                    state_q, state_d;
  logic [AW-1:0]             k_q, k_d, wptr_q, ridx;
  logic signed [DATA_W-1:0]  buf_q [NTAPS];
  logic signed [DATA_W-1:0]  x_q, err_q, x_k, y_q, y_d;
  logic signed [COEF_W-1:0]  w_k;
  logic signed [PW-1:0]      mprod;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      busy_q, vld_q, ovr_q, accept, last;

  // busy_q stays high through the out_valid cycle, so a request there is dropped.
  assign accept = ready_in & ~busy_q;
  assign last   = (k_q == AW'(NTAPS - 1));
  // k-th newest stored sample; wraps naturally modulo NTAPS.
  assign ridx   = wptr_q - AW'(1) - k_q;
  assign x_k    = buf_q[ridx];
  assign mprod  = w_k * x_k;
  assign y_d    = DATA_W'(sat(longint'(acc_q >>> FRAC_BITS), DATA_W));

  assign y_out     = y_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

  lms_coef_bank #(
    .NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
    .MU_SHIFT(MU_SHIFT), .LEAK_SHIFT(LEAK_SHIFT)
  ) u_bank (
    .clk_i(clk_in), .rst_ni(rst_in), .upd_i(state_q == UPDATE),
    .k_i(k_q), .ridx_i(coef_idx_in), .err_i(err_q), .x_i(x_k),
    .w_o(w_k), .coef_o(coef_out)
  );

  // State and tap-counter register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic; the tap counter sweeps 0..NTAPS-1 in UPDATE and FILTER.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE:    if (accept) begin
                 state_d = adapt_en ? UPDATE : INSERT;
                 k_d     = '0;
               end
      UPDATE:  begin
                 k_d = k_q + AW'(1);
                 if (last) state_d = INSERT;
               end
      INSERT:  begin
                 state_d = FILTER;
                 k_d     = '0;
               end
      FILTER:  begin
                 k_d = k_q + AW'(1);
                 if (last) state_d = DONE;
               end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, sample buffer, accumulator and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NTAPS; i++) buf_q[i] <= '0;
      wptr_q <= '0;
      x_q    <= '0;
      err_q  <= '0;
      acc_q  <= '0;
      y_q    <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      vld_q <= (state_q == DONE);
      if (accept) begin
        x_q    <= x_in;
        err_q  <= err_in;
        busy_q <= 1'b1;
      end else if (vld_q) begin
        busy_q <= 1'b0;
      end
      if (ready_in && busy_q) ovr_q <= 1'b1;
      unique case (state_q)
        INSERT: begin
          buf_q[wptr_q] <= x_q;
          wptr_q        <= wptr_q + AW'(1);
          acc_q         <= '0;
        end
        FILTER:  acc_q <= acc_q + ACC_W'(mprod);
        DONE:    y_q   <= y_d;
        default: ;
      endcase
    end
  end

endmodule
